inv_park_seq: RTL and testbench
===============================

Name: inv_park_seq

Overview:
- Sequential inverse Park transform: rotates the rotating-frame pair (D, Q) back into the stationary frame (alpha, beta) using externally supplied fixed-point sin/cos.
  - alpha = D·cos − Q·sin
  - beta = D·sin + Q·cos
- Sits between the current-controller output and the inverse-Clarke/PWM stage; it is the counterpart of the combinational park block.
- Uses one shared multiplier time-multiplexed over four cycles, with valid/ready handshakes on both sides.

Parameters:
- D_WIDTH, 32, signed width of D, Q, sin, cos, alpha, beta.
- Q_BITS, 10, fractional bits of sin/cos (1.0 = 2**Q_BITS); products are shifted right by Q_BITS.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input operands valid.
- in_ready  output  1  block can accept operands.
- D  input  D_WIDTH  signed direct-axis value.
- Q  input  D_WIDTH  signed quadrature-axis value.
- sin  input  D_WIDTH  signed sin(theta), Q_BITS fractional.
- cos  input  D_WIDTH  signed cos(theta), Q_BITS fractional.
- out_valid  output  1  alpha/beta valid.
- out_ready  input  1  downstream accepts result.
- alpha  output  D_WIDTH  signed stationary alpha.
- beta  output  D_WIDTH  signed stationary beta.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, alpha=0, beta=0, internal accumulators=0.
- Reset mid-operation aborts the in-flight transform; no partial result is ever emitted.
- FSM states: IDLE, M0, M1, M2, M3, DONE. in_ready = (state==IDLE) only.
- IDLE: on in_valid && in_ready at edge T, register D/Q/sin/cos, go to M0. Later input changes have no effect.
- M0 (edge T+1): acc_a = D·cos.
- M1 (T+2): acc_a = acc_a − Q·sin.
- M2 (T+3): acc_b = D·sin.
- M3 (T+4): acc_b = acc_b + Q·cos; load alpha = fmt(acc_a) and beta = fmt(acc_b); set out_valid=1; go to DONE.
- Latency: out_valid rises 4 edges after the accepting edge.
- Multiplier: one signed D_WIDTH×D_WIDTH multiplier. Its operands are selected by state; no second multiplier is allowed.
- Accumulator width: 2·D_WIDTH+1 bits signed; no internal overflow is possible.
- fmt(x): arithmetic shift right by Q_BITS (floor rounding toward −inf), then reduce to D_WIDTH per the optional feature.
- DONE: alpha, beta and out_valid are held stable while out_ready=0. On out_valid && out_ready, clear out_valid and go to IDLE. alpha/beta keep their last value.
- Throughput: one transform per 6 cycles minimum. in_valid asserted during M0–DONE is ignored (in_ready=0) and must be held by upstream.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- INV_PARK_SAT_EN defined: fmt saturates to [−2**(D_WIDTH−1), 2**(D_WIDTH−1)−1].
  - Sticky output `sat_flag` (1 bit, reset 0) is set on any clipped alpha/beta.
  - sat_flag is cleared only by reset.
- INV_PARK_SAT_EN undefined: fmt truncates to the low D_WIDTH bits (two's-complement wrap); no sat_flag port.

Test Plan:
- Nominal: D=40, Q=32, sin=887, cos=512 (theta=π/3), out_ready=1.
  - Required: alpha=−8 (−7904>>>10), beta=50 (51864>>>10).
  - out_valid high exactly 4 cycles after the accept edge, for 1 cycle.
- Quadrant 2/3: D=32, Q=40, sin=887, cos=−512.
  - Required: alpha=(−16384−35480)>>>10=−51, beta=(28384−20480)>>>10=7.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises.
  - Required: alpha/beta/out_valid stable, in_ready=0.
  - A new in_valid pulse during this window is not accepted; it is accepted only after out_ready=1 returns the FSM to IDLE.
- Overflow: D=Q=2147483647, sin=cos=1024.
  - Required: alpha=0. beta=2147483647 with sat_flag=1 when INV_PARK_SAT_EN is defined; beta=−2 when it is undefined.
- Reset mid-op: drop rst_n during M2.
  - Required: immediately out_valid=0, alpha=beta=0, in_ready=1. After release, the next transform is correct.
- Zero/identity: D=100, Q=−50, sin=0, cos=1024.
  - Required: alpha=100, beta=−50.

Source files
------------

// File: rtl/inv_park_seq.sv
// Sequential inverse Park transform using one shared multiplier over four cycles.
// Define INV_PARK_SAT_EN to saturate alpha/beta and expose sat_flag; otherwise results wrap.
module inv_park_seq #(
   parameter int D_WIDTH = 32,
   parameter int Q_BITS  = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [D_WIDTH-1:0] D,
   input  logic signed [D_WIDTH-1:0] Q,
   input  logic signed [D_WIDTH-1:0] sin,
   input  logic signed [D_WIDTH-1:0] cos,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [D_WIDTH-1:0] alpha,
`ifdef INV_PARK_SAT_EN
   output logic signed [D_WIDTH-1:0] beta,
   output logic                      sat_flag
`else
   output logic signed [D_WIDTH-1:0] beta
`endif
);

   localparam int AW = 2 * D_WIDTH + 1;

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StM0   = 3'd1;
   localparam logic [2:0] StM1   = 3'd2;
   localparam logic [2:0] StM2   = 3'd3;
   localparam logic [2:0] StM3   = 3'd4;
   localparam logic [2:0] StDone = 3'd5;

   logic [2:0]                state_q, state_d;
   logic signed [D_WIDTH-1:0] d_q, d_d, q_q, q_d, sin_q, sin_d, cos_q, cos_d;
   logic signed [AW-1:0]      acc_a_q, acc_a_d, acc_b_q, acc_b_d;
   logic signed [D_WIDTH-1:0] alpha_q, alpha_d, beta_q, beta_d;
   logic                      out_valid_q, out_valid_d;

   logic signed [D_WIDTH-1:0]   mul_a, mul_b;
   logic signed [2*D_WIDTH-1:0] prod;
   logic signed [AW-1:0]        prod_ext;
   logic signed [D_WIDTH-1:0]   fmt_a, fmt_b;

`ifdef INV_PARK_SAT_EN
   localparam logic signed [AW-1:0] MaxV = {{(D_WIDTH+2){1'b0}}, {(D_WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] MinV = {{(D_WIDTH+2){1'b1}}, {(D_WIDTH-1){1'b0}}};
   localparam logic signed [D_WIDTH-1:0] DMax = {1'b0, {(D_WIDTH-1){1'b1}}};
   localparam logic signed [D_WIDTH-1:0] DMin = {1'b1, {(D_WIDTH-1){1'b0}}};

   logic signed [AW-1:0] sh_a, sh_b;
   logic                 clip_a, clip_b;
   logic                 sat_flag_q, sat_flag_d;
`endif

   // Single multiplier; operand pair chosen by the current step.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state_q)
         StM0:    begin mul_a = d_q; mul_b = cos_q; end
         StM1:    begin mul_a = q_q; mul_b = sin_q; end
         StM2:    begin mul_a = d_q; mul_b = sin_q; end
         StM3:    begin mul_a = q_q; mul_b = cos_q; end
         default: begin mul_a = '0;  mul_b = '0;    end
      endcase
      prod     = mul_a * mul_b;
      prod_ext = {prod[2*D_WIDTH-1], prod};
   end

   always_comb begin
      state_d     = state_q;
      d_d         = d_q;
      q_d         = q_q;
      sin_d       = sin_q;
      cos_d       = cos_q;
      acc_a_d     = acc_a_q;
      acc_b_d     = acc_b_q;
      alpha_d     = alpha_q;
      beta_d      = beta_q;
      out_valid_d = out_valid_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               d_d     = D;
               q_d     = Q;
               sin_d   = sin;
               cos_d   = cos;
               state_d = StM0;
            end
         end
         StM0: begin
            acc_a_d = prod_ext;
            state_d = StM1;
         end
         StM1: begin
            acc_a_d = acc_a_q - prod_ext;
            state_d = StM2;
         end
         StM2: begin
            acc_b_d = prod_ext;
            state_d = StM3;
         end
         StM3: begin
            acc_b_d     = acc_b_q + prod_ext;
            alpha_d     = fmt_a;
            beta_d      = fmt_b;
            out_valid_d = 1'b1;
            state_d     = StDone;
         end
         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // beta is formatted from the accumulator value being written this cycle.
`ifdef INV_PARK_SAT_EN
   always_comb begin
      sh_a   = acc_a_q >>> Q_BITS;
      sh_b   = acc_b_d >>> Q_BITS;
      clip_a = (sh_a > MaxV) || (sh_a < MinV);
      clip_b = (sh_b > MaxV) || (sh_b < MinV);
      fmt_a  = clip_a ? (sh_a[AW-1] ? DMin : DMax) : sh_a[D_WIDTH-1:0];
      fmt_b  = clip_b ? (sh_b[AW-1] ? DMin : DMax) : sh_b[D_WIDTH-1:0];
      sat_flag_d = sat_flag_q | ((state_q == StM3) & (clip_a | clip_b));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sat_flag_q <= 1'b0;
      else        sat_flag_q <= sat_flag_d;
   end

   assign sat_flag = sat_flag_q;
`else
   always_comb begin
      fmt_a = acc_a_q[D_WIDTH-1+Q_BITS:Q_BITS];
      fmt_b = acc_b_d[D_WIDTH-1+Q_BITS:Q_BITS];
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         d_q         <= '0;
         q_q         <= '0;
         sin_q       <= '0;
         cos_q       <= '0;
         acc_a_q     <= '0;
         acc_b_q     <= '0;
         alpha_q     <= '0;
         beta_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         d_q         <= d_d;
         q_q         <= q_d;
         sin_q       <= sin_d;
         cos_q       <= cos_d;
         acc_a_q     <= acc_a_d;
         acc_b_q     <= acc_b_d;
         alpha_q     <= alpha_d;
         beta_q      <= beta_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = out_valid_q;
   assign alpha     = alpha_q;
   assign beta      = beta_q;

endmodule

// File: tb/tb_inv_park_seq.sv
// Directed bench for inv_park_seq: latency, results, backpressure, overflow, mid-op reset.
// Build with INV_PARK_SAT_EN defined to exercise the saturating variant.
module tb_inv_park_seq;

   localparam int W = 32;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic signed [W-1:0] d_in = '0, q_in = '0, sin_in = '0, cos_in = '0;
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic signed [W-1:0] alpha, beta;
`ifdef INV_PARK_SAT_EN
   logic                sat_flag;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   inv_park_seq #(.D_WIDTH(W), .Q_BITS(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .D         (d_in),
      .Q         (q_in),
      .sin       (sin_in),
      .cos       (cos_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alpha     (alpha),
`ifdef INV_PARK_SAT_EN
      .beta      (beta),
      .sat_flag  (sat_flag)
`else
      .beta      (beta)
`endif
   );

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic drive(input int d, input int q, input int s, input int c);
      @(negedge clk);
      d_in     = d;
      q_in     = q;
      sin_in   = s;
      cos_in   = c;
      in_valid = 1'b1;
   endtask

   // Expects in_valid already raised in IDLE; takes the accept edge and waits for the result.
   task automatic accept_and_wait(input string tag, input int exp_a, input int exp_b);
      int lat;
      check({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      d_in     = 32'sd12345;
      q_in     = -32'sd999;
      lat      = 0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      check({tag, "_latency"}, lat, 4);
      check({tag, "_alpha"}, alpha, exp_a);
      check({tag, "_beta"}, beta, exp_b);
   endtask

   task automatic pulse_end(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_pulse_end"}, out_valid, 0);
      check({tag, "_idle_ready"}, in_ready, 1);
   endtask

   initial begin
      #2;
      check("reset_out_valid", out_valid, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_alpha", alpha, 0);
      check("reset_beta", beta, 0);
`ifdef INV_PARK_SAT_EN
      check("reset_sat_flag", sat_flag, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      drive(40, 32, 887, 512);
      accept_and_wait("nominal", -8, 50);
      pulse_end("nominal");

      drive(32, 40, 887, -512);
      accept_and_wait("quadrant", -51, 7);
      pulse_end("quadrant");

      // Backpressure: result must hold and a stray in_valid must be ignored.
      out_ready = 1'b0;
      drive(40, 32, 887, 512);
      accept_and_wait("bp", -8, 50);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = (i == 3);
         d_in     = 7;
         q_in     = 7;
         sin_in   = 0;
         cos_in   = 1024;
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_alpha", alpha, -8);
         check("bp_beta", beta, 50);
      end
      @(negedge clk);
      d_in      = 100;
      q_in      = -50;
      sin_in    = 0;
      cos_in    = 1024;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      check("bp_release_busy", in_ready, 0);
      @(posedge clk);
      #1;
      check("bp_release_idle", in_ready, 1);
      check("bp_release_valid", out_valid, 0);
      @(negedge clk);
      accept_and_wait("identity", 100, -50);
      pulse_end("identity");

      drive(2147483647, 2147483647, 1024, 1024);
      accept_and_wait("overflow", 0,
`ifdef INV_PARK_SAT_EN
                      2147483647);
      check("overflow_sat_flag", sat_flag, 1);
`else
                      -2);
`endif
      pulse_end("overflow");

      // Reset while in M2 must abort and clear the held result immediately.
      drive(32, 40, 887, -512);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_alpha", alpha, 0);
      check("rst_beta", beta, 0);
      check("rst_in_ready", in_ready, 1);
`ifdef INV_PARK_SAT_EN
      check("rst_sat_flag", sat_flag, 0);
`endif
      @(posedge clk);
      #1;
      check("rst_hold_valid", out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;

      drive(40, 32, 887, 512);
      accept_and_wait("post_rst", -8, 50);
      pulse_end("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
